// File: rtl/kb_fib_ctrl.sv
// Keyboard command sequencer: builds a two-digit operand from released-key scan
// codes and launches the Fibonacci engine with a start/ready handshake.
module kb_fib_ctrl #(
    parameter int unsigned N_MAX = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       fib_ready,
    input  logic       fib_done,
    output logic       fib_start,
    output logic       fib_abort,
    output logic [6:0] fib_n,
    output logic [3:0] entry_tens,
    output logic [3:0] entry_units,
    output logic [1:0] entry_cnt,
    output logic       busy,
    output logic       result_valid,
    output logic       err
);

    localparam int unsigned NW = 7;
    localparam int unsigned DW = 4;
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   tens_d, units_d;
    logic [CW-1:0]   cnt_d;
    logic [NW-1:0]   fib_n_d;
    logic            err_d;
    logic            abort_d;

    logic            is_digit, is_enter, is_bksp, is_esc;
    logic [DW-1:0]   digit;
    logic [NW-1:0]   entry_val;

    // Scan-code decode, qualified by the key tick
    always_comb begin
        is_digit = 1'b0;
        is_enter = 1'b0;
        is_bksp  = 1'b0;
        is_esc   = 1'b0;
        digit    = '0;
        if (key_valid) begin
            case (key_code)
                8'h45: begin is_digit = 1'b1; digit = 4'd0; end
                8'h16: begin is_digit = 1'b1; digit = 4'd1; end
                8'h1E: begin is_digit = 1'b1; digit = 4'd2; end
                8'h26: begin is_digit = 1'b1; digit = 4'd3; end
                8'h25: begin is_digit = 1'b1; digit = 4'd4; end
                8'h2E: begin is_digit = 1'b1; digit = 4'd5; end
                8'h36: begin is_digit = 1'b1; digit = 4'd6; end
                8'h3D: begin is_digit = 1'b1; digit = 4'd7; end
                8'h3E: begin is_digit = 1'b1; digit = 4'd8; end
                8'h46: begin is_digit = 1'b1; digit = 4'd9; end
                8'h5A: is_enter = 1'b1;
                8'h66: is_bksp  = 1'b1;
                8'h76: is_esc   = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (entry_cnt)
            2'd2:    entry_val = NW'(entry_tens * 4'd10 + entry_units);
            2'd1:    entry_val = NW'(entry_units);
            default: entry_val = '0;
        endcase
    end

    // Next-state and next register values
    always_comb begin
        state_d = state_q;
        tens_d  = entry_tens;
        units_d = entry_units;
        cnt_d   = entry_cnt;
        fib_n_d = fib_n;
        err_d   = err;
        abort_d = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (is_digit) begin
                    if (entry_cnt < 2'd2) begin
                        tens_d  = (entry_cnt == 2'd1) ? entry_units : 4'd0;
                        units_d = digit;
                        cnt_d   = entry_cnt + 2'd1;
                        err_d   = 1'b0;
                    end
                end else if (is_bksp) begin
                    err_d = 1'b0;
                    if (entry_cnt == 2'd2) begin
                        units_d = entry_tens;
                        tens_d  = '0;
                        cnt_d   = 2'd1;
                    end else if (entry_cnt == 2'd1) begin
                        units_d = '0;
                        cnt_d   = 2'd0;
                    end
                end else if (is_esc) begin
                    tens_d  = '0;
                    units_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (is_enter && entry_cnt != 2'd0) begin
                    if (entry_val > NW'(N_MAX)) begin
                        err_d   = 1'b1;
                        tens_d  = '0;
                        units_d = '0;
                        cnt_d   = '0;
                    end else begin
                        fib_n_d = entry_val;
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                // Esc takes priority over a same-cycle ready
                if (is_esc) begin
                    tens_d  = '0;
                    units_d = '0;
                    cnt_d   = '0;
                    state_d = ST_ENTRY;
                end else if (fib_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (is_esc) begin
                    abort_d = 1'b1;
                    tens_d  = '0;
                    units_d = '0;
                    cnt_d   = '0;
                    state_d = ST_ENTRY;
                end else if (fib_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (is_enter) begin
                    state_d = ST_LAUNCH;
                end else if (is_digit) begin
                    tens_d  = '0;
                    units_d = digit;
                    cnt_d   = 2'd1;
                    state_d = ST_ENTRY;
                end else if (is_esc) begin
                    tens_d  = '0;
                    units_d = '0;
                    cnt_d   = '0;
                    state_d = ST_ENTRY;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_ENTRY;
            entry_tens   <= '0;
            entry_units  <= '0;
            entry_cnt    <= '0;
            fib_n        <= '0;
            err          <= 1'b0;
            fib_abort    <= 1'b0;
            fib_start    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            entry_tens   <= tens_d;
            entry_units  <= units_d;
            entry_cnt    <= cnt_d;
            fib_n        <= fib_n_d;
            err          <= err_d;
            fib_abort    <= abort_d;
            fib_start    <= (state_d == ST_LAUNCH);
            busy         <= (state_d == ST_LAUNCH) || (state_d == ST_RUN);
            result_valid <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_kb_fib_ctrl.sv
// Directed bench for kb_fib_ctrl: entry editing, launch handshake, abort and reset.
module tb_kb_fib_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [7:0] key_code;
    logic       fib_ready;
    logic       fib_done;
    logic       fib_start;
    logic       fib_abort;
    logic [6:0] fib_n;
    logic [3:0] entry_tens;
    logic [3:0] entry_units;
    logic [1:0] entry_cnt;
    logic       busy;
    logic       result_valid;
    logic       err;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] K0 = 8'h45, K1 = 8'h16, K2 = 8'h1E, K3 = 8'h26,
                           K4 = 8'h25, K5 = 8'h2E, K7 = 8'h3D, K9 = 8'h46,
                           KENT = 8'h5A, KBS = 8'h66, KESC = 8'h76;

    kb_fib_ctrl #(.N_MAX(40)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .fib_ready(fib_ready), .fib_done(fib_done), .fib_start(fib_start),
        .fib_abort(fib_abort), .fib_n(fib_n), .entry_tens(entry_tens),
        .entry_units(entry_units), .entry_cnt(entry_cnt), .busy(busy),
        .result_valid(result_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One key tick spanning a single rising edge; outputs sampled at the following negedge
    task automatic press(input logic [7:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic chk_entry(input string tag, input int t, input int u, input int c);
        chk({tag, "_tens"}, 32'(entry_tens), 32'(t));
        chk({tag, "_units"}, 32'(entry_units), 32'(u));
        chk({tag, "_cnt"}, 32'(entry_cnt), 32'(c));
    endtask

    initial begin
        reset = 1'b0; key_valid = 1'b0; key_code = 8'h00;
        fib_ready = 1'b0; fib_done = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_start", 32'(fib_start), 0);
        chk("rst_abort", 32'(fib_abort), 0);
        chk("rst_fib_n", 32'(fib_n), 0);
        chk_entry("rst", 0, 0, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rv", 32'(result_valid), 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b1;
        @(negedge clk);

        // 3,5,Enter with engine ready
        press(K3);
        chk_entry("d3", 0, 3, 1);
        press(K5);
        chk_entry("d35", 3, 5, 2);
        fib_ready = 1'b1;
        press(KENT);
        chk("t1_start", 32'(fib_start), 1);
        chk("t1_fib_n", 32'(fib_n), 35);
        chk("t1_busy", 32'(busy), 1);
        @(negedge clk);
        chk("t1_start_drop", 32'(fib_start), 0);
        chk("t1_busy_run", 32'(busy), 1);
        fib_ready = 1'b0;
        @(negedge clk);
        chk("t1_rv_wait", 32'(result_valid), 0);
        fib_done = 1'b1;
        @(negedge clk);
        fib_done = 1'b0;
        chk("t1_rv", 32'(result_valid), 1);
        chk("t1_busy_done", 32'(busy), 0);
        chk_entry("t1_keep", 3, 5, 2);
        press(KBS);
        chk("done_bksp_rv", 32'(result_valid), 1);
        chk_entry("done_bksp", 3, 5, 2);

        // Digit in DONE starts a new entry; 47 exceeds N_MAX
        press(K4);
        chk("done_dig_rv", 32'(result_valid), 0);
        chk_entry("done_dig", 0, 4, 1);
        press(K7);
        press(KENT);
        chk("t2_err", 32'(err), 1);
        chk("t2_start", 32'(fib_start), 0);
        chk_entry("t2_clr", 0, 0, 0);
        press(K2);
        chk("t2_err_clr", 32'(err), 0);
        chk_entry("t2_d2", 0, 2, 1);

        // Third digit ignored, backspace twice, enter on empty buffer ignored
        press(KESC);
        chk_entry("t3_esc", 0, 0, 0);
        press(K1); press(K2); press(K9);
        chk_entry("t3_129", 1, 2, 2);
        press(KBS);
        chk_entry("t3_bs1", 0, 1, 1);
        press(KBS);
        chk_entry("t3_bs2", 0, 0, 0);
        press(KBS);
        chk_entry("t3_bs3", 0, 0, 0);
        press(KENT);
        chk("t3_enter_start", 32'(fib_start), 0);
        chk("t3_enter_busy", 32'(busy), 0);
        fib_done = 1'b1;
        @(negedge clk);
        fib_done = 1'b0;
        chk("t3_done_ignored", 32'(result_valid), 0);

        // 40 is the boundary value; start held while engine not ready
        press(K4); press(K0);
        press(KENT);
        chk("t4_fib_n", 32'(fib_n), 40);
        chk("t4_err", 32'(err), 0);
        chk("t4_start_c1", 32'(fib_start), 1);
        for (int i = 2; i <= 5; i++) begin
            press(K9);
            chk($sformatf("t4_start_c%0d", i), 32'(fib_start), 1);
        end
        chk_entry("t4_keys_ign", 4, 0, 2);
        fib_ready = 1'b1;
        @(negedge clk);
        fib_ready = 1'b0;
        chk("t4_accept", 32'(fib_start), 0);
        chk("t4_run_busy", 32'(busy), 1);

        // RUN: Esc beats a same-cycle fib_done
        fib_done = 1'b1;
        press(KESC);
        fib_done = 1'b0;
        chk("t5_abort", 32'(fib_abort), 1);
        chk("t5_rv", 32'(result_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk_entry("t5_clr", 0, 0, 0);
        @(negedge clk);
        chk("t5_abort_1cyc", 32'(fib_abort), 0);

        // LAUNCH: Esc beats a same-cycle fib_ready
        press(K5);
        press(KENT);
        chk("t6_start", 32'(fib_start), 1);
        fib_ready = 1'b1;
        press(KESC);
        fib_ready = 1'b0;
        chk("t6_start_drop", 32'(fib_start), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_no_abort", 32'(fib_abort), 0);
        chk_entry("t6_clr", 0, 0, 0);
        @(negedge clk);
        chk("t6_stay_entry", 32'(busy), 0);

        // DONE relaunch with same operand, then reset during LAUNCH
        press(K1); press(K2);
        fib_ready = 1'b1;
        press(KENT);
        @(negedge clk);
        fib_ready = 1'b0;
        fib_done = 1'b1;
        @(negedge clk);
        fib_done = 1'b0;
        chk("t7_rv", 32'(result_valid), 1);
        press(KENT);
        chk("t7_relaunch", 32'(fib_start), 1);
        chk("t7_fib_n", 32'(fib_n), 12);
        chk("t7_rv_low", 32'(result_valid), 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t7_rst_start", 32'(fib_start), 0);
        chk("t7_rst_abort", 32'(fib_abort), 0);
        chk("t7_rst_fib_n", 32'(fib_n), 0);
        chk("t7_rst_busy", 32'(busy), 0);
        chk_entry("t7_rst", 0, 0, 0);
        @(negedge clk);
        chk("t7_post_rst_start", 32'(fib_start), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kb_fib_ctrl.md
# kb_fib_ctrl

Keyboard command sequencer between the PS/2 key-code receiver and the Fibonacci engine. It consumes released-key scan codes, builds a two-digit decimal operand N with editing keys, and launches the engine with a start/ready handshake. It tracks the run to completion and exposes entry digits and status flags for the display logic.

## Interface

Parameters:
- N_MAX, 40, largest accepted operand; must be ≤ 99.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- key_valid  in  1  one-cycle tick: key_code holds a newly released key.
- key_code  in  8  PS/2 set-2 scan code, sampled only when key_valid=1.
- fib_ready  in  1  engine can accept a start.
- fib_done  in  1  one-cycle tick: engine finished current run.
- fib_start  out  1  start request, held until accepted.
- fib_abort  out  1  one-cycle abort pulse to engine.
- fib_n  out  7  operand for the engine, registered.
- entry_tens  out  4  BCD tens digit of the entry buffer.
- entry_units  out  4  BCD units digit of the entry buffer.
- entry_cnt  out  2  digits currently entered (0..2).
- busy  out  1  high in LAUNCH and RUN.
- result_valid  out  1  high in DONE.
- err  out  1  sticky operand-rejected flag.

## Operation

- Decoded keys: 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to digits 0..9; 0x5A Enter; 0x66 Backspace; 0x76 Esc. All other codes are ignored with no state change.
- Entry value V = entry_tens*10 + entry_units when entry_cnt=2, entry_units when entry_cnt=1, and 0 when entry_cnt=0.
- States:
  - ENTRY: reset state.
    - Digit with cnt<2: shift in. At cnt=0, units=d. At cnt=1, tens=units and units=d. cnt increments.
    - Digit with cnt=2: ignored.
    - Backspace: at cnt=2, units=tens and tens=0. At cnt=1, units=0. cnt decrements, saturating at 0.
    - Esc: tens, units and cnt all cleared.
    - Enter with cnt=0: ignored.
    - Enter with V>N_MAX: err=1, buffer cleared, stay in ENTRY.
    - Enter with 1≤cnt and V≤N_MAX: fib_n<=V, go to LAUNCH.
  - LAUNCH: fib_start=1. On a cycle with fib_ready=1, go to RUN. fib_start drops the next cycle. Keys are ignored except Esc, which returns to ENTRY with the buffer cleared, no abort pulse, and fib_start low.
  - RUN: waits for fib_done, then goes to DONE. Esc issues a fib_abort pulse and returns to ENTRY with the buffer cleared. Other keys are ignored.
  - DONE: result_valid=1 and the buffer is retained for display.
    - Enter: relaunch with the same fib_n (go to LAUNCH).
    - Digit: clear the buffer, load the digit as cnt=1, go to ENTRY.
    - Esc: clear the buffer, go to ENTRY.
    - Backspace: ignored.
- err clears on the next accepted digit, Backspace, or Esc in ENTRY. err is set only by a rejected Enter.
- Reset values: state ENTRY; every output 0 (fib_n, digits, cnt, flags, fib_start, fib_abort).

## Timing

- key_valid is processed in the cycle it is high. Register and state effects are visible after the next rising edge (1-cycle latency).
- fib_start is a registered output.
  - It rises 1 cycle after the accepting Enter.
  - The handshake completes on the first edge where fib_start=1 and fib_ready=1.
  - fib_n is stable from the first cycle fib_start is high until the controller leaves RUN.
- fib_abort is high for exactly 1 cycle, the cycle after the Esc is sampled.
- Simultaneous events:
  - In RUN, if fib_done and an Esc key arrive in the same cycle, Esc wins: abort pulse, go to ENTRY, result_valid stays 0.
  - In LAUNCH, if Esc and fib_ready arrive together, Esc wins and no start is accepted.
  - fib_done outside RUN is ignored.
- Reset (reset=0 sampled at an edge) in any state forces reset values the following cycle. A pending fib_start drops immediately; no abort pulse is generated.
- Back-to-back key_valid on consecutive cycles must each be processed.

## Test plan

- Reset, then keys 0x26, 0x2E (3, 5), then 0x5A with fib_ready=1 → entry 3,5, cnt=2; fib_n=35; fib_start high exactly 1 cycle; busy=1. Then fib_done → result_valid=1, busy=0.
- Keys 4, 7, Enter with N_MAX=40 → err=1, cnt=0, no fib_start. Next digit 2 → err=0, units=2.
- Keys 1, 2, 9 (third ignored), then Backspace → tens=0, units=1, cnt=1. Backspace again → cnt=0. Enter → ignored, no start.
- Enter accepted with fib_ready=0 for 5 cycles → fib_start held 5 cycles. fib_ready=1 → accepted, fib_start low next cycle.
- In RUN, Esc and fib_done in the same cycle → fib_abort one cycle, state ENTRY, result_valid=0, buffer cleared.
- In DONE, Enter → fib_start with unchanged fib_n. Assert reset=0 during LAUNCH → all outputs 0 next cycle.
